// File: rtl/main_mem_if.sv
// Cache-to-main-memory handshake bundle: request lines, address/data, and the
// block-sized response with its ready/busy status.
interface main_mem_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
);
  logic                              main_read;
  logic                              main_write;
  logic [ADDR_WIDTH-1:0]             addr;
  logic [DATA_WIDTH-1:0]             wdata;
  logic                              ready;
  logic [DATA_WIDTH*BLOCK_WORDS-1:0] rdata_block;
  logic                              busy;

  modport master (
    output main_read, main_write, addr, wdata,
    input  ready, rdata_block, busy
  );

  modport slave (
    input  main_read, main_write, addr, wdata,
    output ready, rdata_block, busy
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main memory: block refill on main_read, single-word commit on main_write.
// Optional MAIN_MEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module main_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  main_mem_if.slave   bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]                        state;
  logic [CNT_W-1:0]                  cnt;
  logic [ADDR_WIDTH-1:0]             addr_q;
  logic [DATA_WIDTH-1:0]             wdata_q;
  logic [DATA_WIDTH*BLOCK_WORDS-1:0] block_q;
  logic [DATA_WIDTH-1:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]             base;
  logic                              accept;
  logic                              req_held;
  logic                              rd_done;
  logic                              wr_done;

  assign accept   = (state == IDLE) && (bus.main_read ^ bus.main_write);
  assign req_held = (state == RD_WAIT) ? bus.main_read : bus.main_write;
  assign rd_done  = (state == RD_WAIT) && bus.main_read  && (cnt == '0);
  assign wr_done  = (state == WR_WAIT) && bus.main_write && (cnt == '0);
  assign base     = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};

  assign bus.ready       = (state == RESP);
  assign bus.busy        = (state != IDLE);
  assign bus.rdata_block = block_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      block_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= bus.main_read ? RD_WAIT : WR_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // Only the line that opened the transaction can keep it alive.
          if (!req_held)      state <= IDLE;
          else if (cnt == '0) state <= RESP;
          else                cnt   <= cnt - CNT_W'(1);
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (rd_done) begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
          block_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[base | ADDR_WIDTH'(i)];
        end
      end
    end
  end

  // Request operands are captured once at acceptance and then held.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_done) mem[addr_q] <= wdata_q;
  end

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_done && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (wr_done && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized bench for main_mem_responder against a transaction-level memory model.
module tb_main_mem_responder;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int LAT   = 4;
  localparam int BLK_W = DW * BW;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  main_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus ();

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  main_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MAIN_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: expected outputs after the most recent rising edge.
  logic [DW-1:0]    mem_m [0:(1<<AW)-1];
  logic             exp_ready;
  logic             exp_busy;
  logic [BLK_W-1:0] exp_block;
  int               exp_rd;
  int               exp_wr;
  bit               chk_en;

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", BLK_W'(bus.ready), BLK_W'(exp_ready));
      chk("busy", BLK_W'(bus.busy), BLK_W'(exp_busy));
      chk("rdata_block", bus.rdata_block, exp_block);
`ifdef MAIN_MEM_STATS_EN
      chk("rd_count", BLK_W'(rd_count), BLK_W'(exp_rd));
      chk("wr_count", BLK_W'(wr_count), BLK_W'(exp_wr));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.main_read  = 1'b0;
    bus.main_write = 1'b0;
    exp_ready = 1'b0;
    exp_busy  = 1'b0;
    exp_block = '0;
    exp_rd    = 0;
    exp_wr    = 0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  task automatic idle(input int n, input bit conflict);
    bus.main_read  = conflict;
    bus.main_write = conflict;
    for (int k = 0; k < n; k++) begin
      step();
      exp_ready = 1'b0;
      exp_busy  = 1'b0;
    end
    bus.main_read  = 1'b0;
    bus.main_write = 1'b0;
  endtask

  // Request is high for edges 0..hold-1; hold > LAT means it completes at edge LAT.
  task automatic do_txn(input bit rd, input int a, input logic [DW-1:0] d,
                        input int hold, input bit keep);
    int base;
    bit done;
    done = (hold > LAT);
    bus.addr       = AW'(a);
    bus.wdata      = d;
    bus.main_read  = rd;
    bus.main_write = !rd;
    for (int k = 0; k <= LAT + 1; k++) begin
      step();
      if (done) begin
        exp_busy  = (k <= LAT);
        exp_ready = (k == LAT);
        if (k == LAT) begin
          if (rd) begin
            base = a & ~(BW - 1);
            for (int i = 0; i < BW; i++) exp_block[i*DW +: DW] = mem_m[base + i];
            if (exp_rd < 65535) exp_rd++;
          end else begin
            mem_m[a] = d;
            if (exp_wr < 65535) exp_wr++;
          end
        end
      end else begin
        exp_busy  = (k < hold);
        exp_ready = 1'b0;
      end
      bus.addr  = AW'($urandom);
      bus.wdata = $urandom;
      if (k + 1 >= hold && !(keep && done)) begin
        bus.main_read  = 1'b0;
        bus.main_write = 1'b0;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int  r_addr;
  int  r_hold;
  bit  r_rd;
  bit  r_keep;
  bit  prev_keep;
  bit  prev_rd;

  initial begin
    total = 0;
    bad   = 0;
    chk_en = 1'b0;
    exp_ready = 1'b0;
    exp_busy  = 1'b0;
    exp_block = '0;
    exp_rd = 0;
    exp_wr = 0;
    bus.main_read  = 1'b0;
    bus.main_write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    do_reset(2);
    idle(10, 1'b0);

    for (int a = 0; a < 64; a++) do_txn(1'b0, a, $urandom, LAT + 1, 1'b0);

    do_txn(1'b0, 'h005, 32'hDEADBEEF, LAT + 1, 1'b0);
    do_txn(1'b1, 'h006, 32'h0, LAT + 1, 1'b0);
    chk("lit_word1_deadbeef", BLK_W'(bus.rdata_block[1*DW +: DW]), BLK_W'(32'hDEADBEEF));
    chk("lit_model_mem5", BLK_W'(mem_m[5]), BLK_W'(32'hDEADBEEF));

    do_txn(1'b0, 'h005, 32'hCAFEF00D, LAT + 1, 1'b1);
    do_txn(1'b0, 'h005, 32'h00000001, LAT + 1, 1'b0);
    do_txn(1'b1, 'h004, 32'h0, LAT + 1, 1'b0);
    chk("lit_word1_hold", BLK_W'(bus.rdata_block[1*DW +: DW]), BLK_W'(32'h1));

    do_txn(1'b1, 'h010, 32'h0, 2, 1'b0);
    do_txn(1'b0, 'h010, 32'h12345678, 2, 1'b0);
    do_txn(1'b0, 'h011, 32'h87654321, LAT, 1'b0);
    do_txn(1'b1, 'h010, 32'h0, LAT + 1, 1'b0);

    idle(5, 1'b1);
    idle(1, 1'b0);

    bus.addr       = AW'('h020);
    bus.wdata      = 32'h5555AAAA;
    bus.main_write = 1'b1;
    step();
    exp_busy = 1'b1;
    step();
    exp_busy = 1'b1;
    do_reset(2);
    idle(3, 1'b0);
    do_txn(1'b1, 'h020, 32'h0, LAT + 1, 1'b0);

    prev_keep = 1'b0;
    prev_rd   = 1'b0;
    for (int n = 0; n < 150; n++) begin
      r_rd   = prev_keep ? prev_rd : 1'($urandom_range(0, 1));
      r_addr = $urandom_range(0, 63);
      r_hold = ($urandom_range(0, 9) < 7) ? LAT + 1 : $urandom_range(1, LAT);
      r_keep = (r_hold > LAT) && ($urandom_range(0, 3) == 0);
      do_txn(r_rd, r_addr, $urandom, r_hold, r_keep);
      prev_keep = r_keep;
      prev_rd   = r_rd;
      if (!r_keep) idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef MAIN_MEM_STATS_EN
    do_reset(2);
    idle(2, 1'b0);
    do_txn(1'b1, 'h000, 32'h0, LAT + 1, 1'b0);
    do_txn(1'b0, 'h001, 32'hA5A5A5A5, LAT + 1, 1'b0);
    do_txn(1'b1, 'h008, 32'h0, 3, 1'b0);
    do_txn(1'b1, 'h004, 32'h0, LAT + 1, 1'b0);
    do_txn(1'b0, 'h002, 32'h5A5A5A5A, LAT + 1, 1'b0);
    do_txn(1'b1, 'h00C, 32'h0, LAT + 1, 1'b0);
    chk("lit_rd_count", BLK_W'(rd_count), BLK_W'(3));
    chk("lit_wr_count", BLK_W'(wr_count), BLK_W'(2));
`endif

    idle(3, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
